// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared types and constants for the datapath sequencer
package dp_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_LCMP, S_LSTEP, S_DONE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_EXEC, OP_CMP, OP_LOOP} cmd_op_t;
  localparam logic [3:0] CMP_CTRL_DEF = 4'b0001;
endpackage

// File: rtl/dp_seq_ctrl_loop_counter.sv
// loop_counter: loop step counter with clear, increment and terminal compare
module loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_term
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_inc) r_count <= r_count + 1'b1;
  assign o_count = r_count;
  assign o_term  = (r_count == i_limit);
endmodule

// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl: command sequencer driving the register-file/ALU datapath
module dp_seq_ctrl
  import dp_seq_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 5,
  parameter int CNT_WIDTH = 8,
  parameter logic [3:0] CMP_CTRL = CMP_CTRL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [A_WIDTH-1:0]   cmd_rd,
  input  logic [A_WIDTH-1:0]   cmd_rs1,
  input  logic [A_WIDTH-1:0]   cmd_rs2,
  input  logic [D_WIDTH-1:0]   cmd_imm,
  input  logic                 cmd_use_imm,
  input  logic [3:0]           cmd_aluctrl,
  input  logic [CNT_WIDTH-1:0] cmd_max_iter,
  output logic [A_WIDTH-1:0]   ad1,
  output logic [A_WIDTH-1:0]   ad2,
  output logic [A_WIDTH-1:0]   ad3,
  output logic                 we3,
  output logic [D_WIDTH-1:0]   imm_op,
  output logic                 alusrc,
  output logic [3:0]           aluctrl,
  input  logic                 eq,
  output logic                 busy,
  output logic                 done,
  output logic                 flag_eq,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] iter_count
);
  state_t               r_state, w_next;
  cmd_op_t              r_op, w_op;
  logic [A_WIDTH-1:0]   r_rd, r_rs1, r_rs2;
  logic [D_WIDTH-1:0]   r_imm;
  logic                 r_use_imm, r_flag_eq, r_timeout;
  logic [3:0]           r_aluctrl;
  logic [CNT_WIDTH-1:0] r_max_iter;
  logic                 w_accept, w_term;

  assign w_op      = cmd_op_t'(cmd_op);
  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_ready && cmd_valid;
  assign busy      = !cmd_ready;
  assign done      = (r_state == S_DONE);
  assign flag_eq   = r_flag_eq;
  assign timeout   = r_timeout;

  loop_counter #(.W(CNT_WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept && w_op == OP_LOOP),
    .i_inc   (r_state == S_LSTEP),
    .i_limit (r_max_iter),
    .o_count (iter_count),
    .o_term  (w_term)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_aluctrl  <= '0;
      r_max_iter <= '0;
      r_flag_eq  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= w_op;
        r_rd       <= cmd_rd;
        r_rs1      <= cmd_rs1;
        r_rs2      <= cmd_rs2;
        r_imm      <= cmd_imm;
        r_use_imm  <= cmd_use_imm;
        r_aluctrl  <= cmd_aluctrl;
        r_max_iter <= cmd_max_iter;
      end
      if (w_accept && w_op == OP_LOOP) begin
        r_flag_eq <= 1'b0;
        r_timeout <= 1'b0;
      end
      // only a compare updates flag_eq; plain EXEC writes leave it holding
      if (r_state == S_EXEC && r_op == OP_CMP) r_flag_eq <= eq;
      if (r_state == S_LCMP && eq) r_flag_eq <= 1'b1;
      if (r_state == S_LCMP && !eq && w_term) r_timeout <= 1'b1;
    end

  always_comb begin
    w_next  = r_state;
    ad1     = '0;
    ad2     = '0;
    ad3     = '0;
    we3     = 1'b0;
    imm_op  = '0;
    alusrc  = 1'b0;
    aluctrl = '0;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = (w_op == OP_NOP) ? S_DONE : (w_op == OP_LOOP) ? S_LCMP : S_EXEC;
      S_EXEC: begin
        ad1     = r_rs1;
        ad2     = r_rs2;
        ad3     = r_rd;
        we3     = (r_op == OP_EXEC);
        imm_op  = r_imm;
        alusrc  = r_use_imm;
        aluctrl = r_aluctrl;
        w_next  = S_DONE;
      end
      S_LCMP: begin
        ad1     = r_rd;
        ad2     = r_rs2;
        aluctrl = CMP_CTRL;
        w_next  = (eq || w_term) ? S_DONE : S_LSTEP;
      end
      S_LSTEP: begin
        ad1     = r_rd;
        ad3     = r_rd;
        we3     = 1'b1;
        alusrc  = 1'b1;
        imm_op  = r_imm;
        aluctrl = r_aluctrl;
        w_next  = S_LCMP;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dp_seq_ctrl.sv
// tb_dp_seq_ctrl: directed and random commands against a register-file model
module tb_dp_seq_ctrl;
  localparam logic [1:0] NOP = 2'd0, EXE = 2'd1, CMP = 2'd2, LOOP = 2'd3;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;

  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_use_imm = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0, ad1, ad2, ad3;
  logic [7:0] cmd_imm = '0, cmd_max_iter = '0, imm_op, iter_count;
  logic [3:0] cmd_aluctrl = '0, aluctrl;
  logic       we3, alusrc, eq, busy, done, flag_eq, timeout;

  logic [7:0] rf [32];
  logic [7:0] mrf [32];
  int total = 0, bad = 0, wr_cnt = 0, acc_cnt = 0, dn_cnt = 0;
  logic m_fl = 1'b0, m_to = 1'b0;
  logic [7:0] m_it = '0;

  dp_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .cmd_use_imm(cmd_use_imm), .cmd_aluctrl(cmd_aluctrl), .cmd_max_iter(cmd_max_iter),
    .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3), .imm_op(imm_op), .alusrc(alusrc),
    .aluctrl(aluctrl), .eq(eq), .busy(busy), .done(done), .flag_eq(flag_eq),
    .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign eq = (rf[ad1] == (alusrc ? imm_op : rf[ad2]));

  always @(posedge clk) begin
    if (we3) begin
      rf[ad3] <= alu(aluctrl, rf[ad1], alusrc ? imm_op : rf[ad2]);
      wr_cnt  <= wr_cnt + 1;
    end
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    if (done) dn_cnt <= dn_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int r, input logic [7:0] v);
    rf[r] <= v;
    mrf[r] = v;
  endtask

  task automatic chk_rf(input string tag);
    int n = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== mrf[i]) n++;
    chk(tag, n, 0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [7:0] imm, input logic ui,
                         input logic [3:0] ctrl, input logic [7:0] mx);
    logic [7:0] a, b, v, bd;
    int k = 0, ew = 0, en = 1, n = 0, w0;
    a = mrf[rs1];
    b = ui ? imm : mrf[rs2];
    if (op == EXE || op == CMP) begin
      en = 2;
      if (op == EXE) begin
        mrf[rd] = alu(ctrl, a, b);
        ew = 1;
      end else m_fl = (a == b);
    end else if (op == LOOP) begin
      v = mrf[rd];
      bd = mrf[rs2];
      while (v != bd && k < int'(mx)) begin
        v = alu(ctrl, v, imm);
        k++;
      end
      mrf[rd] = v;
      m_fl = (v == bd);
      m_to = !m_fl;
      m_it = 8'(k);
      ew = k;
      en = 2 * k + 2;
    end
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", cmd_ready, 1'b1);
    {cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_use_imm, cmd_aluctrl, cmd_max_iter} =
      {op, rd, rs1, rs2, imm, ui, ctrl, mx};
    cmd_valid = 1'b1;
    w0 = wr_cnt;
    tick();
    cmd_valid = 1'b0;
    n = 1;
    if (op == EXE || op == CMP)
      chk("exec_dp", {ad1, ad2, ad3, we3, imm_op, alusrc, aluctrl},
          {rs1, rs2, rd, op == EXE, imm, ui, ctrl});
    while (!done && n < 600) begin
      tick();
      n++;
    end
    chk("latency", n, en);
    chk("writes", wr_cnt - w0, ew);
    chk("done_busy", {done, busy, we3}, 3'b110);
    if (op != EXE) chk("flag_eq", flag_eq, m_fl);
    chk("timeout_iter", {timeout, iter_count}, {m_to, m_it});
    tick();
    chk("done_pulse", {done, cmd_ready}, 2'b01);
    chk_rf("regfile");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc0, dn0, w0;
    logic [1:0] op;
    for (int i = 0; i < 32; i++) set_reg(i, 8'($urandom_range(0, 15)));
    set_reg(1, 8'd10); set_reg(2, 8'd10); set_reg(3, 8'd0);
    set_reg(4, 8'd0);  set_reg(5, 8'd3);
    set_reg(6, 8'd0);  set_reg(7, 8'd200);
    set_reg(10, 8'd0); set_reg(11, 8'd100);
    set_reg(12, 8'd1); set_reg(13, 8'd2); set_reg(9, 8'd0);
    repeat (2) tick();
    chk("rst_outs", {busy, done, we3, ad1, ad2, ad3, imm_op, alusrc, aluctrl, flag_eq, timeout, iter_count}, '0);
    chk("rst_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    tick();

    // reset landing in the middle of a long loop
    {cmd_op, cmd_rd, cmd_rs2, cmd_imm, cmd_aluctrl, cmd_max_iter} = {LOOP, 5'd6, 5'd7, 8'd1, ADD, 8'd10};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(we3 && iter_count == 8'd2) && n < 40) begin
      tick();
      n++;
    end
    chk("reach_lstep", {we3, iter_count}, {1'b1, 8'd2});
    mrf[6] = 8'd2;
    w0 = wr_cnt;
    rst = 1'b1;
    #1;
    chk("rst_async", {we3, busy, cmd_ready, iter_count, done, flag_eq, timeout}, {3'b001, 8'd0, 3'b000});
    repeat (3) tick();
    chk("rst_nowrite", wr_cnt - w0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_rf("rst_regfile");

    run_cmd(EXE, 5'd3, 5'd1, 5'd0, 8'h05, 1'b1, ADD, 8'd0);
    chk("exec_result", rf[3], 8'd15);
    run_cmd(CMP, 5'd0, 5'd1, 5'd2, 8'h00, 1'b0, SUB, 8'd0);
    chk("cmp_flag", flag_eq, 1'b1);
    run_cmd(LOOP, 5'd4, 5'd0, 5'd5, 8'd1, 1'b0, ADD, 8'd10);
    chk("loop3", {flag_eq, timeout, iter_count, rf[4]}, {2'b10, 8'd3, 8'd3});
    run_cmd(LOOP, 5'd10, 5'd0, 5'd11, 8'd1, 1'b0, ADD, 8'd2);
    chk("loop_to", {flag_eq, timeout, iter_count}, {2'b01, 8'd2});
    run_cmd(LOOP, 5'd10, 5'd0, 5'd11, 8'd1, 1'b0, ADD, 8'd0);
    chk("loop_zero", {flag_eq, timeout, iter_count, rf[10]}, {2'b01, 8'd0, 8'd2});
    run_cmd(NOP, 5'd0, 5'd0, 5'd0, 8'd0, 1'b0, 4'd0, 8'd0);

    // valid held high: NOP accepted every 2 cycles, EXEC every 3
    acc0 = acc_cnt;
    dn0 = dn_cnt;
    cmd_op = NOP;
    cmd_valid = 1'b1;
    repeat (10) tick();
    chk("nop_accepts", acc_cnt - acc0, 5);
    chk("nop_dones", dn_cnt - dn0, 5);
    acc0 = acc_cnt;
    w0 = wr_cnt;
    {cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_aluctrl} = {EXE, 5'd9, 5'd12, 5'd13, 1'b0, ADD};
    repeat (6) tick();
    cmd_valid = 1'b0;
    mrf[9] = 8'd3;
    chk("exec_accepts", acc_cnt - acc0, 2);
    chk("exec_writes", wr_cnt - w0, 2);
    chk_rf("held_regfile");

    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      run_cmd(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? ADD : SUB, 8'($urandom_range(0, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
